// File: rtl/dis_pal_stream_ctrl.sv
// PAL display stream front end: gates video beats into the line FIFO, prefills before
// releasing the display side, and recovers on underflow or frame timeout.
module dis_pal_stream_ctrl #(
    parameter int                     DATA_WIDTH    = 10,
    parameter int                     USEDW_WIDTH   = 10,
    parameter logic [USEDW_WIDTH-1:0] PREFILL_LEVEL = 10'd512,
    parameter logic [USEDW_WIDTH-1:0] HIGH_WATER    = 10'd1000,
    parameter int                     ACLR_CYCLES   = 8,
    parameter logic [23:0]            FRAME_TIMEOUT = 24'd2_000_000
) (
    input  logic                   vst_clk,
    input  logic                   vst_rst_n,
    input  logic [DATA_WIDTH-1:0]  vst_data,
    input  logic                   vst_valid,
    input  logic                   vst_startofpacket,
    input  logic                   vst_endofpacket,
    output logic                   vst_ready,
    output logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_wrreq,
    input  logic [USEDW_WIDTH-1:0] fifo_usedw,
    output logic                   fifo_aclr,
    output logic                   dis_rst_n,
    output logic [2:0]             status_state,
    output logic [7:0]             err_cnt
);

    // state    | meaning
    // IDLE     | post-reset FIFO clear, input stalled
    // WAIT_SOP | drop beats until a start of frame arrives
    // PREFILL  | fill FIFO up to PREFILL_LEVEL, display held in reset
    // RUN      | display running, watching for underflow and frame timeout
    // RECOVER  | FIFO clear after a fault, input stalled
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOP = 3'd1,
        PREFILL  = 3'd2,
        RUN      = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    localparam int CW = (ACLR_CYCLES < 2) ? 1 : $clog2(ACLR_CYCLES + 1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(ACLR_CYCLES);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   clr_cnt;
    logic [23:0]     frame_tmr;
    logic            uf_q;
    logic            accepted;
    logic            sop_acc;
    logic            in_run;
    logic            in_clear;
    logic            usedw_zero;
    logic            underflow;
    logic            timeout;
    logic            clr_done;
    logic            unused_eop;

    assign unused_eop   = vst_endofpacket;
    assign status_state = state;
    assign fifo_data    = vst_data;
    assign in_run       = (state == RUN);
    assign in_clear     = (state == IDLE) || (state == RECOVER);
    assign usedw_zero   = (fifo_usedw == '0);
    assign accepted     = vst_valid & vst_ready;
    assign sop_acc      = accepted & vst_startofpacket;
    assign clr_done     = (clr_cnt <= CW'(1));

    always_comb begin
        vst_ready = 1'b0;
        case (state)
            WAIT_SOP:     vst_ready = 1'b1;
            PREFILL, RUN: vst_ready = (fifo_usedw < HIGH_WATER);
            default:      vst_ready = 1'b0;
        endcase
    end

    assign fifo_wrreq = accepted & ((state == PREFILL) | in_run |
                                    ((state == WAIT_SOP) & vst_startofpacket));

    // Underflow needs two empty, write-less cycles; uf_q remembers the first one.
    assign underflow = in_run & uf_q & usedw_zero & ~fifo_wrreq;
    assign timeout   = in_run & (frame_tmr == FRAME_TIMEOUT - 24'd1) & ~sop_acc;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (clr_done) next_state = WAIT_SOP;
            WAIT_SOP: if (sop_acc) next_state = PREFILL;
            PREFILL:  if (fifo_usedw >= PREFILL_LEVEL) next_state = RUN;
            RUN:      if (underflow || timeout) next_state = RECOVER;
            RECOVER:  if (clr_done) next_state = WAIT_SOP;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge vst_clk or negedge vst_rst_n) begin
        if (!vst_rst_n) begin
            state     <= IDLE;
            clr_cnt   <= CLR_LOAD;
            frame_tmr <= 24'd0;
            err_cnt   <= 8'd0;
            fifo_aclr <= 1'b1;
            dis_rst_n <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            state <= next_state;

            if ((next_state == RECOVER && state != RECOVER) ||
                (next_state == IDLE && state != IDLE))
                clr_cnt <= CLR_LOAD;
            else if (in_clear && clr_cnt != '0)
                clr_cnt <= clr_cnt - CW'(1);

            if (!in_run || sop_acc)
                frame_tmr <= 24'd0;
            else
                frame_tmr <= frame_tmr + 24'd1;

            uf_q <= in_run & usedw_zero & ~fifo_wrreq;

            // Coincident underflow and timeout are a single RECOVER entry.
            if (in_run && (underflow || timeout) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            fifo_aclr <= in_clear;
            dis_rst_n <= in_run;
        end
    end

endmodule
